tx_pkt_arb: RTL and testbench

Packet-granular 2:1 arbiter feeding the single 32-bit TX stream toward the MAC framer. Source 0 is the ARP/ICMP reply generator; source 1 is the IP/UDP packet builder. Grants are held for a whole packet, with round-robin or strict-priority selection. The block enforces a minimum inter-packet gap and aborts packets from a stalled source after a watchdog timeout. It has one registered output stage with ready/valid backpressure.

---
 rtl/tx_pkt_arb.sv | 212 +++++++++++++++++++++
 tb/tb_tx_pkt_arb.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pkt_arb.sv
// tx_pkt_arb: packet-granular 2:1 arbiter onto the 32-bit MAC TX stream.
// Round-robin or strict priority, inter-packet gap, stalled-source watchdog.
`timescale 1ns/1ps
module tx_pkt_arb #(
  parameter int DATA_W  = 32,
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_prio,
  input  logic              s0_req,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_vld,
  input  logic              s0_eop,
  input  logic [1:0]        s0_mty,
  output logic              s0_rdy,
  input  logic              s1_req,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_vld,
  input  logic              s1_eop,
  input  logic [1:0]        s1_mty,
  output logic              s1_rdy,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic [1:0]        dout_mty,
  output logic              dout_err,
  input  logic              dout_rdy,
  output logic [15:0]       cnt_pkt0,
  output logic [15:0]       cnt_pkt1,
  output logic [7:0]        cnt_abort
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    ABORT = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam logic [15:0] TO_LIM  = 16'(TIMEOUT);
  localparam logic [15:0] GAP_LIM = 16'(GAP_CYC);

  state_e            state_q;
  logic              gnt_q;
  logic              last_gnt_q;
  logic              sent_q;
  logic [15:0]       wdog_q;
  logic [15:0]       gap_q;

  logic [DATA_W-1:0] dout_q;
  logic              vld_q;
  logic              sop_q;
  logic              eop_q;
  logic [1:0]        mty_q;
  logic              err_q;

  logic [15:0]       cnt0_q;
  logic [15:0]       cnt1_q;
  logic [7:0]        cnta_q;

  logic              out_free;
  logic              stall;
  logic              xfer;
  logic              src_vld;
  logic [DATA_W-1:0] src_data;
  logic              src_eop;
  logic [1:0]        src_mty;
  logic              beat;
  logic              load_abort;
  logic              any_req;
  logic              pick;
  logic [15:0]       wdog_inc;

  assign out_free = !vld_q | dout_rdy;
  assign stall    = vld_q & !dout_rdy;
  assign xfer     = (state_q == XFER);

  assign s0_rdy = xfer & !gnt_q & out_free;
  assign s1_rdy = xfer &  gnt_q & out_free;

  assign src_vld  = gnt_q ? s1_vld  : s0_vld;
  assign src_data = gnt_q ? s1_data : s0_data;
  assign src_eop  = gnt_q ? s1_eop  : s0_eop;
  assign src_mty  = gnt_q ? s1_mty  : s0_mty;

  assign beat       = xfer & out_free & src_vld;
  assign load_abort = (state_q == ABORT) & out_free;

  // On a tie round robin hands the grant to whoever did not have it last.
  assign any_req  = s0_req | s1_req;
  assign pick     = (s0_req & s1_req) ? (!cfg_prio & !last_gnt_q)
                                      : !s0_req;
  assign wdog_inc = wdog_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      sent_q     <= 1'b0;
      wdog_q     <= '0;
      gap_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q      <= pick;
            last_gnt_q <= pick;
            sent_q     <= 1'b0;
            wdog_q     <= '0;
            state_q    <= XFER;
          end
        end
        XFER: begin
          if (beat) begin
            sent_q <= 1'b1;
            wdog_q <= '0;
            if (src_eop) begin
              gap_q   <= '0;
              state_q <= GAP;
            end
          end else if (!stall) begin
            if (wdog_inc >= TO_LIM) begin
              wdog_q  <= '0;
              state_q <= ABORT;
            end else begin
              wdog_q <= wdog_inc;
            end
          end
        end
        ABORT: begin
          if (out_free) begin
            gap_q   <= '0;
            state_q <= GAP;
          end
        end
        GAP: begin
          // The gap only starts once the closing beat has left downstream.
          if (out_free) begin
            if (gap_q >= GAP_LIM) begin
              state_q <= IDLE;
            end else begin
              gap_q <= gap_q + 16'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
      mty_q  <= 2'd0;
      err_q  <= 1'b0;
    end else if (beat) begin
      dout_q <= src_data;
      vld_q  <= 1'b1;
      sop_q  <= !sent_q;
      eop_q  <= src_eop;
      mty_q  <= src_eop ? src_mty : 2'd0;
      err_q  <= 1'b0;
    end else if (load_abort) begin
      dout_q <= '0;
      vld_q  <= 1'b1;
      sop_q  <= !sent_q;
      eop_q  <= 1'b1;
      mty_q  <= 2'd0;
      err_q  <= 1'b1;
    end else if (dout_rdy) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
      mty_q  <= 2'd0;
      err_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
      cnta_q <= '0;
    end else begin
      if (beat && src_eop && !gnt_q && cnt0_q != 16'hffff)
        cnt0_q <= cnt0_q + 16'd1;
      if (beat && src_eop && gnt_q && cnt1_q != 16'hffff)
        cnt1_q <= cnt1_q + 16'd1;
      if (load_abort && cnta_q != 8'hff)
        cnta_q <= cnta_q + 8'd1;
    end
  end

  assign dout      = dout_q;
  assign dout_vld  = vld_q;
  assign dout_sop  = sop_q;
  assign dout_eop  = eop_q;
  assign dout_mty  = mty_q;
  assign dout_err  = err_q;
  assign cnt_pkt0  = cnt0_q;
  assign cnt_pkt1  = cnt1_q;
  assign cnt_abort = cnta_q;

endmodule

// File: tb/tb_tx_pkt_arb.sv
// tb_tx_pkt_arb: directed stimulus with a queued scoreboard for tx_pkt_arb.
// A negedge monitor pops and compares every beat taken downstream.
`timescale 1ns/1ps
module tb_tx_pkt_arb;

  localparam int GAP = 2;
  localparam int TO  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_prio = 1'b0;
  logic        s0_req = 1'b0;
  logic [31:0] s0_data = '0;
  logic        s0_vld = 1'b0;
  logic        s0_eop = 1'b0;
  logic [1:0]  s0_mty = '0;
  logic        s0_rdy;
  logic        s1_req = 1'b0;
  logic [31:0] s1_data = '0;
  logic        s1_vld = 1'b0;
  logic        s1_eop = 1'b0;
  logic [1:0]  s1_mty = '0;
  logic        s1_rdy;
  logic [31:0] dout;
  logic        dout_vld;
  logic        dout_sop;
  logic        dout_eop;
  logic [1:0]  dout_mty;
  logic        dout_err;
  logic        dout_rdy = 1'b1;
  logic [15:0] cnt_pkt0;
  logic [15:0] cnt_pkt1;
  logic [7:0]  cnt_abort;

  tx_pkt_arb #(.DATA_W(32), .GAP_CYC(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_prio(cfg_prio),
    .s0_req(s0_req), .s0_data(s0_data), .s0_vld(s0_vld),
    .s0_eop(s0_eop), .s0_mty(s0_mty), .s0_rdy(s0_rdy),
    .s1_req(s1_req), .s1_data(s1_data), .s1_vld(s1_vld),
    .s1_eop(s1_eop), .s1_mty(s1_mty), .s1_rdy(s1_rdy),
    .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop),
    .dout_eop(dout_eop), .dout_mty(dout_mty), .dout_err(dout_err),
    .dout_rdy(dout_rdy),
    .cnt_pkt0(cnt_pkt0), .cnt_pkt1(cnt_pkt1), .cnt_abort(cnt_abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  mty;
    logic        err;
  } beat_t;

  beat_t exp_q[$];
  beat_t held;
  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    eop_cyc = 0;
  bit    have_eop = 0;
  bit    hold = 0;
  bit    prio_chk = 0;
  bit    abort_chk = 0;
  bit    err_seen = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic beat_t cur();
    beat_t b;
    b = {dout, dout_sop, dout_eop, dout_mty, dout_err};
    return b;
  endfunction

  task automatic push(input logic [31:0] d, input logic sop,
                      input logic eop, input logic [1:0] mty,
                      input logic err);
    beat_t b;
    b = {d, sop, eop, mty, err};
    exp_q.push_back(b);
  endtask

  task automatic push_pkt(input int n, input logic [31:0] base,
                          input logic [1:0] mty);
    for (int i = 0; i < n; i++)
      push(base + 32'(i), i == 0, i == n - 1,
           (i == n - 1) ? mty : 2'd0, 1'b0);
  endtask

  task automatic mon();
    beat_t e;
    cyc++;
    if (!rst_n) begin
      hold = 0;
      have_eop = 0;
      return;
    end
    if (hold) check("hold_stable", 64'(cur()), 64'(held));
    if (dout_vld && !dout_rdy) begin
      check("stall_rdy", {s0_rdy, s1_rdy}, 0);
      held = cur();
      hold = 1;
    end else begin
      hold = 0;
    end
    check("rdy_onehot", s0_rdy & s1_rdy, 0);
    if (prio_chk && s0_req) check("prio_s1_rdy", s1_rdy, 0);
    if (dout_vld && dout_err) err_seen = 1;
    if (abort_chk && err_seen) check("rdy_after_abort", s0_rdy, 0);
    if (dout_vld && dout_rdy) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL extra_beat: got %h, expected none", cur());
      end else begin
        e = exp_q.pop_front();
        check("beat", 64'(cur()), 64'(e));
      end
      if (dout_sop && have_eop)
        check("gap_len", 64'(cyc - eop_cyc - 1 >= GAP), 1);
      if (dout_eop) begin
        eop_cyc = cyc;
        have_eop = 1;
      end
    end
  endtask

  task automatic send_beat(input int src, input logic [31:0] d,
                           input logic eop, input logic [1:0] mty,
                           input logic req_after, input bit lat);
    int k;
    k = 0;
    if (src == 0) begin
      s0_vld = 1; s0_data = d; s0_eop = eop; s0_mty = mty;
    end else begin
      s1_vld = 1; s1_data = d; s1_eop = eop; s1_mty = mty;
    end
    forever begin
      @(negedge clk);
      if (src == 0 ? s0_rdy : s1_rdy) break;
      k++;
      if (k > 300) begin
        n_chk++;
        n_fail++;
        $display("FAIL src%0d_rdy_timeout: got none, expected rdy", src);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (lat) check("latency", dout, d);
    if (src == 0) begin
      s0_vld = 0; s0_req = req_after;
    end else begin
      s1_vld = 0; s1_req = req_after;
    end
  endtask

  task automatic send_pkt(input int src, input int n,
                          input logic [31:0] base, input logic [1:0] mty,
                          input logic keep, input bit lat);
    if (src == 0) s0_req = 1; else s1_req = 1;
    for (int i = 0; i < n; i++)
      send_beat(src, base + 32'(i), i == n - 1,
                (i == n - 1) ? mty : 2'd3, keep, lat);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      k++;
      if (k > 500) begin
        n_chk++;
        n_fail++;
        $display("FAIL drain_timeout: got %0d beats left, expected 0",
                 exp_q.size());
        exp_q.delete();
      end
    end
    repeat (GAP + 4) @(negedge clk);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        mon();
      end
      begin
        #200000;
        $display("FAIL global_timeout: got hang, expected finish");
        $fatal(1, "timeout");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {dout, dout_vld, dout_sop, dout_eop, dout_mty,
                       dout_err, s0_rdy, s1_rdy}, 0);
    check("rst_cnt", {cnt_pkt0, cnt_pkt1, cnt_abort}, 0);
    rst_n = 1;
    @(posedge clk);
    #1;

    // single source 1, three beats
    push_pkt(3, 32'hA000_0001, 2'd2);
    send_pkt(1, 3, 32'hA000_0001, 2'd2, 0, 1);
    drain();
    check("t1_cnt1", cnt_pkt1, 1);
    check("t1_cnt0", cnt_pkt0, 0);

    // round robin on a tie
    cfg_prio = 0;
    push_pkt(1, 32'hB000_0000, 2'd1);
    push_pkt(1, 32'hC000_0000, 2'd3);
    push_pkt(1, 32'hB000_0001, 2'd1);
    push_pkt(1, 32'hC000_0001, 2'd3);
    fork
      begin
        send_pkt(0, 1, 32'hB000_0000, 2'd1, 1, 0);
        send_pkt(0, 1, 32'hB000_0001, 2'd1, 0, 0);
      end
      begin
        send_pkt(1, 1, 32'hC000_0000, 2'd3, 1, 0);
        send_pkt(1, 1, 32'hC000_0001, 2'd3, 0, 0);
      end
    join
    drain();
    check("t2_cnt0", cnt_pkt0, 2);
    check("t2_cnt1", cnt_pkt1, 3);

    // strict priority
    cfg_prio = 1;
    prio_chk = 1;
    for (int i = 0; i < 4; i++) push_pkt(1, 32'hD000_0000 + 32'(i), 2'd0);
    push_pkt(1, 32'hE000_0000, 2'd2);
    fork
      begin
        for (int i = 0; i < 4; i++)
          send_pkt(0, 1, 32'hD000_0000 + 32'(i), 2'd0, i < 3, 0);
      end
      send_pkt(1, 1, 32'hE000_0000, 2'd2, 0, 0);
    join
    drain();
    prio_chk = 0;
    cfg_prio = 0;
    check("t3_cnt0", cnt_pkt0, 6);
    check("t3_cnt1", cnt_pkt1, 4);

    // downstream stall mid-packet
    push_pkt(4, 32'hF000_0010, 2'd1);
    fork
      send_pkt(1, 4, 32'hF000_0010, 2'd1, 0, 0);
      begin
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (dout_vld && dout_sop) break;
        end
        @(posedge clk);
        #1 dout_rdy = 0;
        repeat (2) @(posedge clk);
        #1 dout_rdy = 1;
      end
    join
    drain();
    check("t4_cnt1", cnt_pkt1, 5);
    check("t4_abort", cnt_abort, 0);

    // watchdog abort
    abort_chk = 1;
    err_seen = 0;
    push(32'h1234_5678, 1, 0, 2'd0, 0);
    push(32'h0, 0, 1, 2'd0, 1);
    s0_req = 1;
    send_beat(0, 32'h1234_5678, 0, 2'd3, 0, 0);
    drain();
    check("t5_abort", cnt_abort, 1);
    check("t5_cnt0", cnt_pkt0, 6);
    abort_chk = 0;
    push_pkt(2, 32'h5500_0000, 2'd0);
    send_pkt(1, 2, 32'h5500_0000, 2'd0, 0, 0);
    drain();
    check("t5_cnt1", cnt_pkt1, 6);

    // reset mid-packet
    push(32'h6600_0000, 1, 0, 2'd0, 0);
    s1_req = 1;
    send_beat(1, 32'h6600_0000, 0, 2'd3, 0, 0);
    send_beat(1, 32'h6600_0001, 0, 2'd3, 0, 0);
    rst_n = 0;
    #1;
    check("t6_outs", {dout, dout_vld, dout_sop, dout_eop, dout_mty,
                      dout_err, s0_rdy, s1_rdy}, 0);
    check("t6_cnt", {cnt_pkt0, cnt_pkt1, cnt_abort}, 0);
    check("t6_flush", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    push_pkt(1, 32'h7700_0000, 2'd1);
    push_pkt(1, 32'h8800_0000, 2'd2);
    fork
      send_pkt(0, 1, 32'h7700_0000, 2'd1, 0, 0);
      send_pkt(1, 1, 32'h8800_0000, 2'd2, 0, 0);
    join
    drain();
    check("t6_cnt_after", {cnt_pkt0, cnt_pkt1, cnt_abort},
          {16'd1, 16'd1, 8'd0});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
